input_buffer_ctrl: RTL
======================

Name: input_buffer_ctrl

Overview:
- Sequencer for the input_buffer dual-port RAM.
- Loads a burst of input words from an upstream valid/ready stream into consecutive buffer addresses.
- Replays the stored vector, in address order, one or more times to the downstream MAC/neuron datapath over a valid/ready stream, with full backpressure.
- Sits between the input DMA/stream source and input_buffer; the buffer's registered read port is part of the output pipeline.

Parameters:
- CTRL_DATA_WIDTH, default DATA_WIDTH: width of data words (matches the buffer).
- CTRL_ADDR_WIDTH, default ADDR_WIDTH: buffer address width. DEPTH = 2**CTRL_ADDR_WIDTH.
- PASS_WIDTH, default 8: width of the replay-pass count.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_start  in  1  pulse: begin a load of cfg_len words.
- stream_start  in  1  pulse: begin replay of the loaded vector.
- cfg_len  in  CTRL_ADDR_WIDTH+1  vector length in words; sampled on an accepted load_start.
- cfg_passes  in  PASS_WIDTH  replay count; sampled on an accepted stream_start.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller accepts an upstream word.
- in_data  in  CTRL_DATA_WIDTH signed  upstream word.
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  CTRL_DATA_WIDTH signed  downstream word; equals buf_rd_data.
- out_last  out  1  qualifies the final word of each pass.
- busy  out  1  high in LOAD or STREAM.
- load_done  out  1  one-cycle pulse when a load completes.
- done  out  1  one-cycle pulse when all passes complete.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- buf_wr_en  out  1  buffer write enable.
- buf_wr_addr  out  CTRL_ADDR_WIDTH  buffer write address.
- buf_wr_data  out  CTRL_DATA_WIDTH  buffer write data.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  CTRL_ADDR_WIDTH  buffer read address.
- buf_rd_data  in  CTRL_DATA_WIDTH  buffer read data, valid one cycle after buf_rd_en and held while buf_rd_en is low.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; all counters 0; loaded length 0.
  - in_ready, out_valid, out_last, busy, load_done, done, cfg_err, buf_wr_en, buf_rd_en are all 0.
- States: IDLE, LOAD, LOADED, STREAM.
- IDLE:
  - load_start with 1 <= cfg_len <= DEPTH -> latch len, wr_cnt=0, go to LOAD.
  - load_start with cfg_len == 0 or cfg_len > DEPTH -> cfg_err pulse next cycle; stay in IDLE.
  - stream_start -> ignored.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready (same cycle): buf_wr_en=1, buf_wr_addr=wr_cnt, buf_wr_data=in_data; wr_cnt++ (combinational drive; write lands at the edge).
  - After the len-th accepted word -> LOADED next cycle; load_done pulses for one cycle on that entry; in_ready drops.
  - load_start and stream_start are ignored in LOAD.
- LOADED:
  - Buffer contents are retained.
  - load_start takes priority over a simultaneous stream_start: it is validated as in IDLE; if invalid, cfg_err pulses and the state stays LOADED.
  - stream_start with cfg_passes == 0 -> cfg_err pulse, stay in LOADED.
  - stream_start with cfg_passes != 0 -> latch passes, rd_cnt=0, pass_cnt=0, go to STREAM.
- STREAM, issue rule (combinational):
  - buf_rd_en = issue_pending && (!out_valid || out_ready).
  - buf_rd_addr = rd_cnt.
  - On issue: rd_cnt wraps to 0 after len-1, and pass_cnt increments on that wrap.
  - issue_pending clears once len*passes reads have issued.
- STREAM, output register:
  - On issue, out_valid <= 1 next cycle; otherwise out_valid <= out_valid && !out_ready.
  - out_last is registered alongside out_valid: 1 when the issued address was len-1.
  - out_data = buf_rd_data; it holds under a stall because buf_rd_en stays low.
  - Throughput is 1 word/cycle when out_ready is held high. First out_valid appears 2 cycles after the stream_start edge (1 cycle to enter STREAM, 1 cycle of buffer read latency).
- Stream completion: when the final word (last of the final pass) handshakes -> LOADED next cycle, done pulses for one cycle, out_valid = 0.
- Write/read ordering: no buffer write occurs in STREAM and no read occurs in LOAD, so there are never same-address collisions.
- Reset mid-LOAD or mid-STREAM: immediate return to IDLE; the partial vector is discarded (loaded length cleared). A new load is required before streaming.
- busy = (state == LOAD) || (state == STREAM).

Test Plan:
1. Basic load and stream: load_start, cfg_len=4; words 10,-3,7,5 with in_valid held high -> buf_wr_addr 0..3 written; load_done pulses. Then stream_start, cfg_passes=1, out_ready=1 -> out_data 10,-3,7,5 on consecutive cycles, out_last on the 5; done pulses; state returns to LOADED.
2. Replay: same vector, cfg_passes=3 -> 12 words in order, out_last on words 4, 8, 12; single done pulse after word 12.
3. Backpressure: out_ready toggled 1,0,0,1,... -> no word dropped or duplicated; out_data stable while out_valid && !out_ready; buf_rd_en low during stalls.
4. Upstream gaps: in_valid with bubbles -> only handshaked words are written, at contiguous addresses; load_done only after the 4th accept.
5. Config errors: cfg_len=0, cfg_len=DEPTH+1, cfg_passes=0, and stream_start in IDLE -> cfg_err pulses for the first three, nothing for stream_start in IDLE; state unchanged; no buffer access in any case. cfg_len=DEPTH is accepted.
6. Reset and priority: rst_n low during word 2 of STREAM -> all outputs 0 asynchronously, then IDLE, stream_start ignored. Separately, in LOADED, load_start and stream_start asserted together -> LOAD is entered.

Source files
------------

// File: rtl/input_buffer_ctrl_if.sv
// Handshake and buffer-port bundle for the input buffer sequencer.
// master = controller side, slave = stream source/sink and buffer side.
interface input_buffer_ctrl_if #(
  parameter int CTRL_DATA_WIDTH = 16,
  parameter int CTRL_ADDR_WIDTH = 4
);
  // upstream stream
  logic                              in_valid;
  logic                              in_ready;
  logic signed [CTRL_DATA_WIDTH-1:0] in_data;
  // downstream stream
  logic                              out_valid;
  logic                              out_ready;
  logic signed [CTRL_DATA_WIDTH-1:0] out_data;
  logic                              out_last;
  // buffer write port
  logic                              buf_wr_en;
  logic [CTRL_ADDR_WIDTH-1:0]        buf_wr_addr;
  logic [CTRL_DATA_WIDTH-1:0]        buf_wr_data;
  // buffer read port (registered read data)
  logic                              buf_rd_en;
  logic [CTRL_ADDR_WIDTH-1:0]        buf_rd_addr;
  logic [CTRL_DATA_WIDTH-1:0]        buf_rd_data;

  modport master (
    input  in_valid, in_data, out_ready, buf_rd_data,
    output in_ready, out_valid, out_data, out_last,
           buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr
  );

  modport slave (
    output in_valid, in_data, out_ready, buf_rd_data,
    input  in_ready, out_valid, out_data, out_last,
           buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_en, buf_rd_addr
  );
endinterface

// File: rtl/input_buffer_ctrl.sv
// Sequencer for the input buffer RAM: loads a burst of words from the
// upstream stream, then replays the stored vector one or more times to the
// downstream datapath. The buffer's registered read port is the first
// output pipeline stage; out_valid/out_last ride alongside it.
module input_buffer_ctrl #(
  parameter int CTRL_DATA_WIDTH = 16,
  parameter int CTRL_ADDR_WIDTH = 4,
  parameter int PASS_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       stream_start,
  input  logic [CTRL_ADDR_WIDTH:0]   cfg_len,
  input  logic [PASS_WIDTH-1:0]      cfg_passes,
  output logic                       busy,
  output logic                       load_done,
  output logic                       done,
  output logic                       cfg_err,
  input_buffer_ctrl_if.master        bus
);

  localparam int AW = CTRL_ADDR_WIDTH;
  localparam int PW = PASS_WIDTH;
  localparam logic [AW:0]   DEPTH    = (AW+1)'(2**AW);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [PW-1:0] PASS_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, LOADED, STREAM} state_t;

  state_t        state_reg;
  logic [AW:0]   len_reg;
  logic [AW:0]   wr_cnt_reg;
  logic [AW-1:0] rd_cnt_reg;
  logic [PW-1:0] passes_reg;
  logic [PW-1:0] pass_cnt_reg;
  logic          issue_pending_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic          load_done_reg;
  logic          done_reg;
  logic          cfg_err_reg;

  logic len_ok;
  logic wr_fire;
  logic rd_issue;
  logic rd_at_end;
  logic final_hs;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= DEPTH);
  assign wr_fire   = (state_reg == LOAD) && bus.in_valid;
  // a read is issued whenever the output register is empty or draining
  assign rd_issue  = (state_reg == STREAM) && issue_pending_reg &&
                     (!out_valid_reg || bus.out_ready);
  assign rd_at_end = ({1'b0, rd_cnt_reg} == (len_reg - LEN_ONE));
  // once no reads remain pending, the out_last word in the register is the final one
  assign final_hs  = (state_reg == STREAM) && out_valid_reg && bus.out_ready &&
                     out_last_reg && !issue_pending_reg;

  assign bus.in_ready    = (state_reg == LOAD);
  assign bus.buf_wr_en   = wr_fire;
  assign bus.buf_wr_addr = wr_cnt_reg[AW-1:0];
  assign bus.buf_wr_data = bus.in_data;
  assign bus.buf_rd_en   = rd_issue;
  assign bus.buf_rd_addr = rd_cnt_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_last    = out_last_reg;
  assign bus.out_data    = bus.buf_rd_data;

  assign busy      = (state_reg == LOAD) || (state_reg == STREAM);
  assign load_done = load_done_reg;
  assign done      = done_reg;
  assign cfg_err   = cfg_err_reg;

  // control FSM with counters and registered status/output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      len_reg           <= '0;
      wr_cnt_reg        <= '0;
      rd_cnt_reg        <= '0;
      passes_reg        <= '0;
      pass_cnt_reg      <= '0;
      issue_pending_reg <= 1'b0;
      out_valid_reg     <= 1'b0;
      out_last_reg      <= 1'b0;
      load_done_reg     <= 1'b0;
      done_reg          <= 1'b0;
      cfg_err_reg       <= 1'b0;
    end else begin
      load_done_reg <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_start) begin
            if (len_ok) begin
              len_reg    <= cfg_len;
              wr_cnt_reg <= '0;
              state_reg  <= LOAD;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wr_cnt_reg <= wr_cnt_reg + LEN_ONE;
            if ((wr_cnt_reg + LEN_ONE) == len_reg) begin
              state_reg     <= LOADED;
              load_done_reg <= 1'b1;
            end
          end
        end
        LOADED: begin
          // a new load wins over a simultaneous stream request
          if (load_start) begin
            if (len_ok) begin
              len_reg    <= cfg_len;
              wr_cnt_reg <= '0;
              state_reg  <= LOAD;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end else if (stream_start) begin
            if (cfg_passes == '0) begin
              cfg_err_reg <= 1'b1;
            end else begin
              passes_reg        <= cfg_passes;
              rd_cnt_reg        <= '0;
              pass_cnt_reg      <= '0;
              issue_pending_reg <= 1'b1;
              state_reg         <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_issue) begin
            out_valid_reg <= 1'b1;
            out_last_reg  <= rd_at_end;
            if (rd_at_end) begin
              rd_cnt_reg   <= '0;
              pass_cnt_reg <= pass_cnt_reg + PASS_ONE;
              if ((pass_cnt_reg + PASS_ONE) == passes_reg) begin
                issue_pending_reg <= 1'b0;
              end
            end else begin
              rd_cnt_reg <= rd_cnt_reg + ADDR_ONE;
            end
          end else begin
            out_valid_reg <= out_valid_reg && !bus.out_ready;
          end
          if (final_hs) begin
            state_reg     <= LOADED;
            done_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
